// File: rtl/pipelined_addsub_if.sv
// Handshake and data bundle for pipelined_addsub.
// The master side issues operations and takes results; the slave side is the arithmetic unit.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: one SEG_W-bit segment resolved per stage, segment carry registered
// between stages, followed by an output register that holds result and flags until handshaked.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input logic               clk,
  input logic               rst,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / SEG_W;

  // Stage k holds an operation whose segments 0..k-1 are already summed in s_q[k].
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] co_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             zero_d;

  assign advance = !out_valid_q || bus.out_ready;
  assign accept  = bus.in_valid && advance;
  assign b_in    = bus.sub ? ~bus.b : bus.b;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [SEG_W:0] tot;
    assign tot     = {1'b0, a_q[k][k*SEG_W +: SEG_W]}
                   + {1'b0, b_q[k][k*SEG_W +: SEG_W]}
                   + {{SEG_W{1'b0}}, c_q[k]};
    // Unfinished sum bits are kept at zero, so OR-ing the new segment in is enough.
    assign s_d[k]  = s_q[k] | (WIDTH'(tot[SEG_W-1:0]) << (k*SEG_W));
    assign co_d[k] = tot[SEG_W];
  end

  assign res_d  = s_d[STAGES-1];
  assign ovf_d  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                  (res_d[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  assign zero_d = (res_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q         <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      v_q[0] <= accept;
      if (accept) begin
        a_q[0] <= bus.a;
        b_q[0] <= b_in;
        s_q[0] <= '0;
        c_q[0] <= bus.sub;
      end
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
          s_q[k] <= s_d[k-1];
          c_q[k] <= co_d[k-1];
        end
      end
      // Output data only changes when a real operation lands; bubbles leave it as-is.
      out_valid_q <= v_q[STAGES-1];
      if (v_q[STAGES-1]) begin
        result_q   <= res_d;
        carry_q    <= co_d[STAGES-1];
        overflow_q <= ovf_d;
        zero_q     <= zero_d;
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
endmodule
